// File: rtl/write_s_sram_if.sv
// -----------------------------------------------------------------------------
// write_s_sram_if
// Bundles the write_s_sram handshake, S RAM read ports and SRAM write bus.
//   write_s_start / block_row / block_col : start request and block position
//   busy / write_s_finish                 : status back to the controlling FSM
//   s_address_a/b, s_read_data_a/b        : S dual-port RAM read ports
//   sram_address / sram_write_data / sram_we_n : external SRAM write bus
// Modports:
//   master : controller + S RAM side (drives start, block indices, S RAM data)
//   slave  : the write_s_sram block
// -----------------------------------------------------------------------------
interface write_s_sram_if;
    logic        write_s_start;
    logic [4:0]  block_row;
    logic [5:0]  block_col;
    logic [6:0]  s_address_a;
    logic [6:0]  s_address_b;
    logic [31:0] s_read_data_a;
    logic [31:0] s_read_data_b;
    logic [17:0] sram_address;
    logic [15:0] sram_write_data;
    logic        sram_we_n;
    logic        busy;
    logic        write_s_finish;

    modport master (
        output write_s_start, block_row, block_col, s_read_data_a, s_read_data_b,
        input  s_address_a, s_address_b, sram_address, sram_write_data, sram_we_n,
               busy, write_s_finish
    );

    modport slave (
        input  write_s_start, block_row, block_col, s_read_data_a, s_read_data_b,
        output s_address_a, s_address_b, sram_address, sram_write_data, sram_we_n,
               busy, write_s_finish
    );
endinterface

// File: rtl/write_s_sram.sv
// -----------------------------------------------------------------------------
// write_s_sram
// Last stage of the per-block IDCT: reads the 8x8 S matrix two entries per
// cycle, scales (arithmetic shift) and clips each entry to an 8-bit pixel,
// packs pixel pairs into 16-bit words and writes the 32 words of the block to
// the Y plane in external SRAM. Pulses write_s_finish for one cycle when done.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : write_s_sram_if.slave (start/indices, S RAM reads, SRAM writes,
//           busy and finish status)
// -----------------------------------------------------------------------------
module write_s_sram #(
    parameter int unsigned SHIFT     = 16,
    parameter int unsigned ROW_WORDS = 160,
    parameter logic [17:0] BASE_ADDR = 18'd0
) (
    input  logic          clock,
    input  logic          reset,
    write_s_sram_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StPrime, StRun, StDone} state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [4:0]  r_row;
    logic [5:0]  r_col;
    logic [4:0]  r_k;
    logic [6:0]  r_s_addr_a;
    logic [6:0]  r_s_addr_b;
    logic [17:0] r_sram_addr;
    logic [15:0] r_sram_data;
    logic        r_we_n;
    logic        r_busy;
    logic        r_finish;

    logic [4:0]  w_row_next;
    logic [5:0]  w_col_next;
    logic [4:0]  w_k_next;
    logic [6:0]  w_s_addr_a_next;
    logic [6:0]  w_s_addr_b_next;
    logic [17:0] w_sram_addr_next;
    logic [15:0] w_sram_data_next;
    logic        w_we_n_next;
    logic        w_busy_next;
    logic        w_finish_next;

    logic [17:0] w_pix_row;
    logic [17:0] w_word_addr;
    logic [15:0] w_packed;

    // Scale one raw S entry and clip it to an unsigned 8-bit pixel.
    function automatic logic [7:0] pix(input logic [31:0] s);
        logic signed [31:0] v;
        v = $signed(s) >>> SHIFT;
        if (v < 0) begin
            return 8'd0;
        end else if (v > 32'sd255) begin
            return 8'hFF;
        end else begin
            return v[7:0];
        end
    endfunction

    // Word k covers S row k/4, columns 2*(k%4) and 2*(k%4)+1, so the image row
    // is block_row*8 + k[4:2] and the word column is block_col*4 + k[1:0].
    // Both sums are plain concatenations because the low fields never carry.
    assign w_pix_row   = 18'({r_row, r_k[4:2]});
    assign w_word_addr = BASE_ADDR + w_pix_row * 18'(ROW_WORDS) + 18'({r_col, r_k[1:0]});
    assign w_packed    = {pix(bus.s_read_data_a), pix(bus.s_read_data_b)};

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.write_s_start) w_state_next = StPrime;
            StPrime: w_state_next = StRun;
            StRun:   if (r_k == 5'd31) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_row_next       = r_row;
        w_col_next       = r_col;
        w_k_next         = r_k;
        w_s_addr_a_next  = r_s_addr_a;
        w_s_addr_b_next  = r_s_addr_b;
        w_sram_addr_next = r_sram_addr;
        w_sram_data_next = r_sram_data;
        w_we_n_next      = 1'b1;
        w_busy_next      = r_busy;
        w_finish_next    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.write_s_start) begin
                    w_row_next      = bus.block_row;
                    w_col_next      = bus.block_col;
                    w_s_addr_a_next = 7'd0;
                    w_s_addr_b_next = 7'd1;
                    w_k_next        = 5'd0;
                    w_busy_next     = 1'b1;
                end
            end
            StPrime: begin
                // Entries 0/1 are already in flight; queue up 2/3.
                w_s_addr_a_next = 7'd2;
                w_s_addr_b_next = 7'd3;
            end
            StRun: begin
                w_we_n_next      = 1'b0;
                w_sram_data_next = w_packed;
                w_sram_addr_next = w_word_addr;
                if (r_k != 5'd31) begin
                    w_s_addr_a_next = r_s_addr_a + 7'd2;
                    w_s_addr_b_next = r_s_addr_b + 7'd2;
                    w_k_next        = r_k + 5'd1;
                end
            end
            StDone: begin
                w_finish_next = 1'b1;
                w_busy_next   = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath / output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_row       <= 5'd0;
            r_col       <= 6'd0;
            r_k         <= 5'd0;
            r_s_addr_a  <= 7'd0;
            r_s_addr_b  <= 7'd1;
            r_sram_addr <= 18'd0;
            r_sram_data <= 16'd0;
            r_we_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
        end else begin
            r_row       <= w_row_next;
            r_col       <= w_col_next;
            r_k         <= w_k_next;
            r_s_addr_a  <= w_s_addr_a_next;
            r_s_addr_b  <= w_s_addr_b_next;
            r_sram_addr <= w_sram_addr_next;
            r_sram_data <= w_sram_data_next;
            r_we_n      <= w_we_n_next;
            r_busy      <= w_busy_next;
            r_finish    <= w_finish_next;
        end
    end

    assign bus.s_address_a     = r_s_addr_a;
    assign bus.s_address_b     = r_s_addr_b;
    assign bus.sram_address    = r_sram_addr;
    assign bus.sram_write_data = r_sram_data;
    assign bus.sram_we_n       = r_we_n;
    assign bus.busy            = r_busy;
    assign bus.write_s_finish  = r_finish;

endmodule

// File: tb/tb_write_s_sram.sv
// -----------------------------------------------------------------------------
// tb_write_s_sram
// Directed bench for write_s_sram. A timing/pixel model derived from block
// geometry is checked against the DUT every cycle; literal expectations pin
// selected writes of each scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_write_s_sram;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    write_s_sram_if bus();

    write_s_sram #(
        .SHIFT     (16),
        .ROW_WORDS (160),
        .BASE_ADDR (18'd0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // S dual-port RAM: registered read, one cycle after address.
    logic [31:0] s_mem [128];
    always @(posedge clock) begin
        bus.s_read_data_a <= s_mem[bus.s_address_a];
        bus.s_read_data_b <= s_mem[bus.s_address_b];
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // t counts edges since the accepted start (1 = start edge); 0 = idle.
    int         t = 0;
    logic [4:0] m_row;
    logic [5:0] m_col;

    always @(posedge clock) begin
        if (reset) begin
            t <= 0;
        end else if ((t == 0 || t >= 35) && bus.write_s_start) begin
            t     <= 1;
            m_row <= bus.block_row;
            m_col <= bus.block_col;
        end else if (t >= 35) begin
            t <= 0;
        end else if (t != 0) begin
            t <= t + 1;
        end
    end

    function automatic logic [7:0] m_pix(input logic [31:0] s);
        longint v;
        longint rem;
        v   = longint'($signed(s));
        rem = ((v % 65536) + 65536) % 65536;
        v   = (v - rem) / 65536;  // floor division by 2^16
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    function automatic logic [17:0] m_addr(input int k);
        int y;
        int x;
        y = int'(m_row) * 8 + k / 4;
        x = int'(m_col) * 8 + 2 * (k % 4);
        return 18'(y * 160 + x / 2);
    endfunction

    function automatic logic [15:0] m_data(input int k);
        int r;
        int c;
        r = k / 4;
        c = 2 * (k % 4);
        return {m_pix(s_mem[r * 8 + c]), m_pix(s_mem[r * 8 + c + 1])};
    endfunction

    // ---------------- compare / monitor ----------------
    logic [33:0] wr_q [$];
    int          fin_count  = 0;
    int          busy_count = 0;

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy",   64'(bus.busy),           64'(t >= 1 && t <= 34));
            check("we_n",   64'(bus.sram_we_n),      64'(!(t >= 3 && t <= 34)));
            check("finish", 64'(bus.write_s_finish), 64'(t == 35));
            if (t >= 3 && t <= 34) begin
                check("addr", 64'(bus.sram_address),    64'(m_addr(t - 3)));
                check("data", 64'(bus.sram_write_data), 64'(m_data(t - 3)));
            end
            if (!bus.sram_we_n) wr_q.push_back({bus.sram_address, bus.sram_write_data});
            if (bus.write_s_finish) fin_count++;
            if (bus.busy) busy_count++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        wr_q.delete();
        fin_count  = 0;
        busy_count = 0;
    endtask

    task automatic pulse_start(input logic [4:0] row, input logic [5:0] col);
        bus.block_row     = row;
        bus.block_col     = col;
        bus.write_s_start = 1'b1;
        tick(1);
        bus.write_s_start = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 128; i++) s_mem[i] = 32'(i % 64) << 16;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) s_mem[i] = 32'd0;
        bus.write_s_start = 1'b0;
        bus.block_row     = 5'd0;
        bus.block_col     = 6'd0;
        reset             = 1'b1;
        tick(3);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset values
        check("rst_addr",  64'(bus.sram_address),    64'd0);
        check("rst_data",  64'(bus.sram_write_data), 64'd0);
        check("rst_sa",    64'(bus.s_address_a),     64'd0);
        check("rst_sb",    64'(bus.s_address_b),     64'd1);
        check("rst_we_n",  64'(bus.sram_we_n),       64'd1);
        tick(2);

        // 1: zero block at (0,0)
        clear_mon();
        pulse_start(5'd0, 6'd0);
        tick(40);
        check("t1_count",  64'(wr_q.size()), 64'd32);
        check("t1_fin",    64'(fin_count),   64'd1);
        check("t1_busy",   64'(busy_count),  64'd34);
        check("t1_first",  64'(wr_q[0]),     64'({18'd0, 16'h0000}));
        check("t1_w4",     64'(wr_q[4]),     64'({18'd160, 16'h0000}));
        check("t1_last",   64'(wr_q[31]),    64'({18'd1123, 16'h0000}));

        // 2: ramp at block (1,2)
        fill_ramp();
        clear_mon();
        pulse_start(5'd1, 6'd2);
        tick(40);
        check("t2_count",  64'(wr_q.size()), 64'd32);
        check("t2_first",  64'(wr_q[0]),     64'({18'd1288, 16'h0001}));
        check("t2_last",   64'(wr_q[31]),    64'({18'd2411, 16'h3E3F}));

        // 3: clipping
        for (int i = 0; i < 128; i++) s_mem[i] = 32'd0;
        s_mem[0] = 32'hFFFF_0000;
        s_mem[1] = 32'd300 << 16;
        s_mem[2] = (32'd255 << 16) + 32'h0000_FFFF;
        clear_mon();
        pulse_start(5'd0, 6'd0);
        tick(40);
        check("t3_w0",     64'(wr_q[0]),     64'({18'd0, 16'h00FF}));
        check("t3_w1",     64'(wr_q[1]),     64'({18'd1, 16'hFF00}));

        // 4: start re-asserted during RUN with different indices
        fill_ramp();
        clear_mon();
        pulse_start(5'd3, 6'd5);
        tick(10);
        bus.block_row     = 5'd7;
        bus.block_col     = 6'd9;
        bus.write_s_start = 1'b1;
        tick(5);
        bus.write_s_start = 1'b0;
        tick(30);
        check("t4_count",  64'(wr_q.size()), 64'd32);
        check("t4_fin",    64'(fin_count),   64'd1);
        check("t4_first",  64'(wr_q[0]),     64'({18'd3860, 16'h0001}));
        check("t4_last",   64'(wr_q[31]),    64'({18'd4983, 16'h3E3F}));

        // 5: reset on the edge that would register k=10
        clear_mon();
        pulse_start(5'd2, 6'd3);
        tick(11);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_we_n",   64'(bus.sram_we_n), 64'd1);
        check("t5_busy",   64'(bus.busy),      64'd0);
        tick(40);
        check("t5_count",  64'(wr_q.size()), 64'd10);
        check("t5_fin",    64'(fin_count),   64'd0);
        clear_mon();
        pulse_start(5'd2, 6'd3);
        tick(40);
        check("t5b_count", 64'(wr_q.size()), 64'd32);
        check("t5b_fin",   64'(fin_count),   64'd1);
        check("t5b_last",  64'(wr_q[31]),    64'({18'd3695, 16'h3E3F}));

        // 6: back-to-back, start held high
        clear_mon();
        bus.block_row     = 5'd29;
        bus.block_col     = 6'd39;
        bus.write_s_start = 1'b1;
        tick(6);
        bus.block_row     = 5'd0;
        bus.block_col     = 6'd0;
        tick(30);  // now just past edge 36, where the second start is taken
        bus.write_s_start = 1'b0;
        tick(40);
        check("t6_count",  64'(wr_q.size()), 64'd64);
        check("t6_fin",    64'(fin_count),   64'd2);
        check("t6_first",  64'(wr_q[0]),     64'({18'd37276, 16'h0001}));
        check("t6_last1",  64'(wr_q[31]),    64'({18'd38399, 16'h3E3F}));
        check("t6_first2", 64'(wr_q[32]),    64'({18'd0, 16'h0001}));

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
